// File: rtl/code_conv_pkg.sv
// Shared types and helpers for Gray-code conversion and count-change classification.
package code_conv_pkg;

  typedef enum logic [1:0] {PRIME, TRACK, HOLD} state_t;

  localparam logic [15:0] DELTA_UP = 16'h0001;
  localparam logic [15:0] DELTA_DN = 16'hFFFF;

  // Unused upper bits of g must be zero; each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a bus crossing in from an unrelated clock domain.
module sync_chain #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronises a foreign-domain Gray count, decodes it and flags up/down steps or illegal jumps.
module gray_sync_decoder
  import code_conv_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_async,
  input  logic             en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             jump_err,
  output logic             err_sticky,
  output logic             tracking
);

  localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);
  localparam logic [WIDTH-1:0] UP_W       = DELTA_UP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DN_W       = DELTA_DN[WIDTH-1:0];

  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] prev_g;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] delta;
  logic [15:0]      g_ext;
  logic [15:0]      b_ext;
  logic [2:0]       cnt;
  state_t           state;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (g_async),
    .q     (g_sync)
  );

  always_comb begin
    g_ext              = '0;
    g_ext[WIDTH-1:0]   = g_sync;
    b_ext              = gray2bin(g_ext);
    bin                = b_ext[WIDTH-1:0];
    delta              = bin - b_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIME;
      cnt        <= '0;
      prev_g     <= '0;
      b_out      <= '0;
      b_valid    <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      jump_err   <= 1'b0;
      err_sticky <= 1'b0;
      tracking   <= 1'b0;
    end else begin
      b_valid   <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      jump_err  <= 1'b0;
      // A jump detected this cycle overrides a concurrent clear below.
      if (clr_err) err_sticky <= 1'b0;

      case (state)
        PRIME: begin
          if (cnt == PRIME_LAST) begin
            b_out    <= bin;
            prev_g   <= g_sync;
            tracking <= 1'b1;
            cnt      <= '0;
            state    <= TRACK;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        TRACK: begin
          if (!en) begin
            tracking <= 1'b0;
            state    <= HOLD;
          end else if (g_sync != prev_g) begin
            prev_g  <= g_sync;
            b_out   <= bin;
            b_valid <= 1'b1;
            if (delta == UP_W) begin
              step_up <= 1'b1;
            end else if (delta == DN_W) begin
              step_down <= 1'b1;
            end else begin
              jump_err   <= 1'b1;
              err_sticky <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Re-prime so any movement while disabled reloads silently.
          if (en) begin
            cnt   <= '0;
            state <= PRIME;
          end
        end
        default: begin
          cnt   <= '0;
          state <= PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Scoreboard bench: stimulus picks binary counts, a monitor checks every b_valid against the queue.
module tb_gray_sync_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] g_async;
  logic       en;
  logic       clr_err;
  logic [2:0] b_out;
  logic       b_valid, step_up, step_down, jump_err, err_sticky, tracking;

  typedef struct {
    int b;
    int kind;  // 0 up, 1 down, 2 jump
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   cur    = 0;
  int   up_seen = 0;
  int   model_jumps = 0;

  gray_sync_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .g_async    (g_async),
    .en         (en),
    .clr_err    (clr_err),
    .b_out      (b_out),
    .b_valid    (b_valid),
    .step_up    (step_up),
    .step_down  (step_down),
    .jump_err   (jump_err),
    .err_sticky (err_sticky),
    .tracking   (tracking)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] g_of(input int v);
    logic [2:0] x;
    x = 3'(v);
    return x ^ (x >> 1);
  endfunction

  // Move the source count to v; the expected event is derived from the count difference.
  task automatic change_to(input int v);
    exp_t e;
    int d;
    v = v & 7;
    if (v != cur) begin
      d = (v - cur + 8) % 8;
      e.b    = v;
      e.kind = (d == 1) ? 0 : (d == 7) ? 1 : 2;
      e.due  = cyc + 3;
      if (e.kind == 2) model_jumps++;
      q.push_back(e);
    end
    cur = v;
    g_async = g_of(v);
  endtask

  task automatic wait_track();
    int n = 0;
    while (!tracking && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("track_timeout", int'(tracking), 1);
  endtask

  always @(negedge clk) begin
    if (b_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b_valid: got b_out=%0d with no pending change", b_out);
      end else begin
        exp_t e;
        int got_k, exp_k;
        e = q.pop_front();
        got_k = {step_up, step_down, jump_err};
        exp_k = (e.kind == 0) ? 4 : (e.kind == 1) ? 2 : 1;
        chk("b_out", int'(b_out), e.b);
        chk("class", got_k, exp_k);
        chk("latency", cyc, e.due);
        if (e.kind == 2) chk("err_set", int'(err_sticky), 1);
        if (step_up) up_seen++;
      end
    end else if (step_up || step_down || jump_err) begin
      checks++;
      errors++;
      $display("FAIL pulse_no_valid: got up=%0d dn=%0d jmp=%0d expected none", step_up, step_down, jump_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int up0;
    rst_n = 1'b0; en = 1'b1; clr_err = 1'b0; g_async = 3'b110;
    repeat (3) @(negedge clk);
    chk("rst_b_out", int'(b_out), 0);
    chk("rst_err", int'(err_sticky), 0);
    chk("rst_track", int'(tracking), 0);
    rst_n = 1'b1;
    cur = 4;
    @(negedge clk);
    chk("prime1_b_out", int'(b_out), 0);
    chk("prime1_track", int'(tracking), 0);
    @(negedge clk);
    chk("prime2_b_out", int'(b_out), 0);
    chk("prime2_track", int'(tracking), 0);
    @(negedge clk);
    chk("prime_b_out", int'(b_out), 4);
    chk("prime_track", int'(tracking), 1);
    chk("prime_jump", int'(jump_err), 0);

    // Re-prime at zero, then count up through the wrap.
    rst_n = 1'b0; g_async = 3'b000; cur = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_track();
    chk("zero_b_out", int'(b_out), 0);
    up0 = up_seen;
    for (int i = 1; i <= 8; i++) begin
      change_to(i);
      repeat (4) @(negedge clk);
    end
    chk("up_count", up_seen - up0, 8);
    chk("up_no_err", int'(err_sticky), 0);

    change_to(7);
    repeat (4) @(negedge clk);
    chk("down_b_out", int'(b_out), 7);

    change_to(0); repeat (4) @(negedge clk);
    change_to(1); repeat (4) @(negedge clk);
    chk("pre_jump_err", int'(err_sticky), 0);
    change_to(6); repeat (4) @(negedge clk);
    chk("jump_b_out", int'(b_out), 6);
    chk("jump_sticky", int'(err_sticky), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_sticky", int'(err_sticky), 0);
    change_to(2);
    @(negedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("set_wins", int'(err_sticky), 1);
    repeat (2) @(negedge clk);

    // Disabled: the source moves 2 -> 5 without being tracked.
    en = 1'b0;
    g_async = g_of(5); cur = 5;
    repeat (8) @(negedge clk);
    chk("hold_b_out", int'(b_out), 2);
    chk("hold_track", int'(tracking), 0);
    chk("hold_sticky", int'(err_sticky), 1);
    en = 1'b1;
    @(negedge clk);
    chk("reen1_track", int'(tracking), 0);
    @(negedge clk);
    chk("reen2_track", int'(tracking), 0);
    wait_track();
    chk("reen_b_out", int'(b_out), 5);

    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    model_jumps = 0;
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      change_to(cur + 1);
      else if (r < 8) change_to(cur + 7);
      else            change_to($urandom_range(0, 7));
      repeat ($urandom_range(4, 6)) @(negedge clk);
    end
    chk("rand_sticky", int'(err_sticky), (model_jumps > 0) ? 1 : 0);

    change_to(cur + 4); repeat (4) @(negedge clk);
    if (cur != 6) begin
      change_to(6); repeat (4) @(negedge clk);
    end
    chk("pre_arst_b_out", int'(b_out), 6);
    chk("pre_arst_err", int'(err_sticky), 1);
    chk("queue_drained", q.size(), 0);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_b_out", int'(b_out), 0);
    chk("arst_err", int'(err_sticky), 0);
    chk("arst_track", int'(tracking), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_prime_track", int'(tracking), 0);
    wait_track();
    chk("arst_reload", int'(b_out), 6);
    chk("arst_reload_err", int'(err_sticky), 0);
    repeat (3) @(negedge clk);
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
